// File: rtl/intt_gs_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly: (a+b) and (a-b)*w mod q, Shoup multiply,
// optional halving, 3-stage valid/ready pipeline.
module intt_gs_butterfly #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_w,
  input  logic [DW-1:0] in_wp,
  input  logic [DW-1:0] in_q,
  input  logic          in_halve,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b
);

  typedef struct packed {
    logic          v;
    logic          halve;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic [DW-1:0] w;
    logic [DW-1:0] wp;
    logic [DW-1:0] q;
  } s1_t;

  typedef struct packed {
    logic          v;
    logic          halve;
    logic [DW-1:0] sum;
    logic [DW-1:0] z;
    logic [DW-1:0] t;
    logic [DW-1:0] q;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  logic [DW:0]   qx;
  logic [DW:0]   sum_raw;
  logic [DW:0]   diff_raw;
  logic [DW-1:0] sum1;
  logic [DW-1:0] diff1;

  assign qx       = {1'b0, in_q};
  assign sum_raw  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_raw = {1'b0, in_a} + qx - {1'b0, in_b};
  assign sum1     = DW'(sum_raw >= qx ? sum_raw - qx : sum_raw);
  assign diff1    = DW'(diff_raw >= qx ? diff_raw - qx : diff_raw);

  logic [DW-1:0]   z2;
  logic [DW-1:0]   t2;
  logic [2*DW-1:0] pt;

  // Low half of diff*w and high half of diff*wp; their
  // difference with t*q lands in [0,2q) by Shoup's bound.
  assign z2 = s1.diff * s1.w;
  assign pt = {{DW{1'b0}}, s1.diff} * {{DW{1'b0}}, s1.wp};
  assign t2 = DW'(pt >> DW);

  logic [DW-1:0] r_raw;
  logic [DW-1:0] r3;
  logic [DW-1:0] a3;
  logic [DW-1:0] b3;

  function automatic logic [DW-1:0] halve_mod(
    input logic [DW-1:0] x,
    input logic [DW-1:0] q
  );
    logic [DW:0] s;
    s = x[0] ? {1'b0, x} + {1'b0, q} : {1'b0, x};
    return DW'(s >> 1);
  endfunction

  assign r_raw = s2.z - s2.t * s2.q;
  assign r3    = r_raw >= s2.q ? r_raw - s2.q : r_raw;
  assign a3    = s2.halve ? halve_mod(s2.sum, s2.q) : s2.sum;
  assign b3    = s2.halve ? halve_mod(r3, s2.q) : r3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (en) begin
      s1.v      <= in_valid;
      s1.halve  <= in_halve;
      s1.sum    <= sum1;
      s1.diff   <= diff1;
      s1.w      <= in_w;
      s1.wp     <= in_wp;
      s1.q      <= in_q;
      s2.v      <= s1.v;
      s2.halve  <= s1.halve;
      s2.sum    <= s1.sum;
      s2.z      <= z2;
      s2.t      <= t2;
      s2.q      <= s1.q;
      out_valid <= s2.v;
      out_a     <= a3;
      out_b     <= b3;
    end
  end

endmodule
